// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the 5-stage MIPS core.
// Resolves the next PC from D-stage redirects (jr > jump > branch), keeping one delay slot.
module fetch_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int unsigned IM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        clr_d,
    input  logic        br_taken,
    input  logic        jump,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic [31:0] im_addr,
    input  logic [31:0] im_rdata,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc8_d,
    output logic        fetch_err_d
);

    localparam logic [32:0] PC_LO = {1'b0, PC_RESET};
    localparam logic [32:0] PC_HI = {1'b0, PC_RESET} + (33'(IM_DEPTH) << 2);

    // Misaligned or outside the instruction-memory window; compared in 33 bits so the
    // upper bound never overflows.
    function automatic logic fetch_addr_bad(input logic [31:0] addr);
        logic [32:0] a_ext;
        a_ext = {1'b0, addr};
        return (addr[1:0] != 2'b00) || (a_ext < PC_LO) || (a_ext >= PC_HI);
    endfunction

    logic [31:0] pc_if_q,    pc_if_d;
    logic [31:0] instr_id_q, instr_id_d;
    logic [31:0] pc_id_q,    pc_id_d;
    logic [31:0] pc8_id_q,   pc8_id_d;
    logic        err_id_q,   err_id_d;

    logic [31:0] pc_plus4_s;
    logic [31:0] pc_plus8_s;
    logic [31:0] br_tgt_s;
    logic [31:0] j_tgt_s;
    logic        fetch_bad_s;

    // Redirect targets and fetch-address check
    always_comb begin
        pc_plus4_s  = pc_if_q + 32'd4;
        pc_plus8_s  = pc_if_q + 32'd8;
        br_tgt_s    = pc_id_q + 32'd4 + {{14{instr_id_q[15]}}, instr_id_q[15:0], 2'b00};
        j_tgt_s     = {pc_id_q[31:28], instr_id_q[25:0], 2'b00};
        fetch_bad_s = fetch_addr_bad(pc_if_q);
    end

    // Next PC: the stalled D instruction keeps its redirect request alive until release
    always_comb begin
        pc_if_d = pc_plus4_s;
        if (stall) begin
            pc_if_d = pc_if_q;
        end else if (jr) begin
            pc_if_d = jr_target;
        end else if (jump) begin
            pc_if_d = j_tgt_s;
        end else if (br_taken) begin
            pc_if_d = br_tgt_s;
        end else begin
            pc_if_d = pc_plus4_s;
        end
    end

    // IF/ID next state: bubble beats hold; a bad fetch address injects a nop
    always_comb begin
        instr_id_d = instr_id_q;
        pc_id_d    = pc_id_q;
        pc8_id_d   = pc8_id_q;
        err_id_d   = err_id_q;
        if (clr_d) begin
            instr_id_d = 32'd0;
            pc_id_d    = 32'd0;
            pc8_id_d   = 32'd0;
            err_id_d   = 1'b0;
        end else if (stall) begin
            instr_id_d = instr_id_q;
            pc_id_d    = pc_id_q;
            pc8_id_d   = pc8_id_q;
            err_id_d   = err_id_q;
        end else if (fetch_bad_s) begin
            instr_id_d = 32'd0;
            pc_id_d    = pc_if_q;
            pc8_id_d   = pc_plus8_s;
            err_id_d   = 1'b1;
        end else begin
            instr_id_d = im_rdata;
            pc_id_d    = pc_if_q;
            pc8_id_d   = pc_plus8_s;
            err_id_d   = 1'b0;
        end
    end

    // PC and IF/ID registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_if_q    <= PC_RESET;
            instr_id_q <= 32'd0;
            pc_id_q    <= 32'd0;
            pc8_id_q   <= 32'd0;
            err_id_q   <= 1'b0;
        end else begin
            pc_if_q    <= pc_if_d;
            instr_id_q <= instr_id_d;
            pc_id_q    <= pc_id_d;
            pc8_id_q   <= pc8_id_d;
            err_id_q   <= err_id_d;
        end
    end

    assign im_addr     = pc_if_q;
    assign instr_d     = instr_id_q;
    assign pc_d        = pc_id_q;
    assign pc8_d       = pc8_id_q;
    assign fetch_err_d = err_id_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, branches, stall/redirect, bad fetches, bubble, async reset.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        clr_d;
    logic        br_taken;
    logic        jump;
    logic        jr;
    logic [31:0] jr_target;
    logic [31:0] im_addr;
    logic [31:0] im_rdata;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc8_d;
    logic        fetch_err_d;

    logic [31:0] mem [0:1023];
    int checks;
    int errors;

    fetch_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .clr_d(clr_d),
        .br_taken(br_taken), .jump(jump), .jr(jr), .jr_target(jr_target),
        .im_addr(im_addr), .im_rdata(im_rdata), .instr_d(instr_d),
        .pc_d(pc_d), .pc8_d(pc8_d), .fetch_err_d(fetch_err_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory at 0x3000..0x3FFC; anything else reads a loud marker value
    assign im_rdata = (im_addr >= 32'h0000_3000 && im_addr < 32'h0000_4000)
                      ? mem[im_addr[11:2]] : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_d(input string tag, input logic [31:0] e_instr, input logic [31:0] e_pc,
                         input logic [31:0] e_pc8, input logic e_err, input logic [31:0] e_addr);
        chk({tag, "_instr"}, instr_d, e_instr);
        chk({tag, "_pc"},    pc_d, e_pc);
        chk({tag, "_pc8"},   pc8_d, e_pc8);
        chk({tag, "_err"},   {31'd0, fetch_err_d}, {31'd0, e_err});
        chk({tag, "_addr"},  im_addr, e_addr);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h2400_0000 + i;
        mem[1] = 32'h1000_0003;   // beq at 0x3004, imm +3
        mem[5] = 32'h1000_FFFF;   // beq at 0x3014, imm -1
        mem[6] = 32'h0800_0C10;   // j 0x3040 at 0x3018

        reset = 1'b0; stall = 1'b0; clr_d = 1'b0; br_taken = 1'b0;
        jump = 1'b0; jr = 1'b0; jr_target = 32'd0;

        // 1. reset state, then sequential fetch
        repeat (3) step();
        chk_d("rst", 32'd0, 32'd0, 32'd0, 1'b0, 32'h3000);
        reset = 1'b1;
        step();
        chk_d("w0", 32'h2400_0000, 32'h3000, 32'h3008, 1'b0, 32'h3004);
        step();
        chk_d("beq_p", 32'h1000_0003, 32'h3004, 32'h300C, 1'b0, 32'h3008);

        // 2. taken branch, delay slot enters D, target 0x3004+4+12
        br_taken = 1'b1;
        step();
        chk_d("slot_p", 32'h2400_0002, 32'h3008, 32'h3010, 1'b0, 32'h3014);
        br_taken = 1'b0;
        step();
        chk_d("beq_n", 32'h1000_FFFF, 32'h3014, 32'h301C, 1'b0, 32'h3018);
        br_taken = 1'b1;
        step();
        chk_d("slot_n", 32'h0800_0C10, 32'h3018, 32'h3020, 1'b0, 32'h3014);
        br_taken = 1'b0;
        step();
        chk("beq_n2_pc", pc_d, 32'h3014);
        step();
        chk_d("jinstr", 32'h0800_0C10, 32'h3018, 32'h3020, 1'b0, 32'h301C);

        // 3. stall with branch and jump held; jump wins once stall drops
        stall = 1'b1; br_taken = 1'b1; jump = 1'b1;
        step();
        chk_d("stall1", 32'h0800_0C10, 32'h3018, 32'h3020, 1'b0, 32'h301C);
        step();
        chk_d("stall2", 32'h0800_0C10, 32'h3018, 32'h3020, 1'b0, 32'h301C);
        stall = 1'b0;
        step();
        chk_d("jslot", 32'h2400_0007, 32'h301C, 32'h3024, 1'b0, 32'h3040);
        br_taken = 1'b0; jump = 1'b0;
        step();
        chk_d("jtgt", 32'h2400_0010, 32'h3040, 32'h3048, 1'b0, 32'h3044);

        // 4. jr to misaligned and out-of-range targets
        jr = 1'b1; jr_target = 32'h3002;
        step();
        chk_d("jrslot", 32'h2400_0011, 32'h3044, 32'h304C, 1'b0, 32'h3002);
        jr = 1'b0;
        step();
        chk_d("misal", 32'd0, 32'h3002, 32'h300A, 1'b1, 32'h3006);
        jr = 1'b1; jr_target = 32'h4000;
        step();
        chk_d("misal2", 32'd0, 32'h3006, 32'h300E, 1'b1, 32'h4000);
        jr = 1'b0;
        step();
        chk_d("oor", 32'd0, 32'h4000, 32'h4008, 1'b1, 32'h4004);
        jr = 1'b1; jr_target = 32'h3000;
        step();
        chk("oor2_err", {31'd0, fetch_err_d}, 32'd1);
        chk("oor2_addr", im_addr, 32'h3000);
        jr = 1'b0;
        step();
        chk_d("recov", 32'h2400_0000, 32'h3000, 32'h3008, 1'b0, 32'h3004);

        // 5. bubble together with stall: IF/ID cleared, PC held
        clr_d = 1'b1; stall = 1'b1;
        step();
        chk_d("clr", 32'd0, 32'd0, 32'd0, 1'b0, 32'h3004);
        clr_d = 1'b0; stall = 1'b0;
        step();
        chk_d("afterclr", 32'h1000_0003, 32'h3004, 32'h300C, 1'b0, 32'h3008);

        // last legal word, then PC wrap at the top of the address space
        jr = 1'b1; jr_target = 32'h3FFC;
        step();
        chk("last_slot_addr", im_addr, 32'h3FFC);
        jr = 1'b0;
        step();
        chk_d("last", 32'h2400_03FF, 32'h3FFC, 32'h4004, 1'b0, 32'h4000);
        jr = 1'b1; jr_target = 32'hFFFF_FFFC;
        step();
        chk("top_addr", im_addr, 32'hFFFF_FFFC);
        jr = 1'b0;
        step();
        chk_d("top", 32'd0, 32'hFFFF_FFFC, 32'h0000_0004, 1'b1, 32'h0000_0000);
        step();
        chk_d("wrap", 32'd0, 32'h0000_0000, 32'h0000_0008, 1'b1, 32'h0000_0004);

        // 6. asynchronous reset between edges
        step();
        #2;
        reset = 1'b0;
        #1;
        chk_d("arst", 32'd0, 32'd0, 32'd0, 1'b0, 32'h3000);
        step();
        reset = 1'b1;
        step();
        chk_d("arst_w0", 32'h2400_0000, 32'h3000, 32'h3008, 1'b0, 32'h3004);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
